// File: rtl/serial_adder_if.sv
// serial_adder_if: start/done handshake and operand/result bus of the bit-serial adder
interface serial_adder_if #(parameter int W = 8);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder, one full-adder cell plus carry flop, W+1 cycles per add
module serial_adder #(parameter int W = 8) (
    input logic            clk,
    input logic            rst_n,
    serial_adder_if.slave  bus
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        state;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [W-1:0]  r_sh;
    logic          c;
    logic [CW-1:0] cnt;
    logic          s;
    logic          c_nx;
    logic [W-1:0]  r_nx;
    // full-adder cell; the new sum bit enters the working result from the MSB side
    always_comb begin
        s    = a_sh[0] ^ b_sh[0] ^ c;
        c_nx = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
        r_nx = (r_sh >> 1) | (W'(s) << (W - 1));
    end
    // sequencing FSM; sum/cout are loaded only at RUN exit so they never show partial results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            r_sh     <= '0;
            c        <= 1'b0;
            cnt      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.sum  <= '0;
            bus.cout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        a_sh     <= bus.a;
                        b_sh     <= bus.b;
                        c        <= bus.cin;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    c    <= c_nx;
                    r_sh <= r_nx;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        bus.sum  <= r_nx;
                        bus.cout <= c_nx;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
